// File: rtl/decode_stage.sv
// Registered RV32I OP / OP-IMM decoder with valid/ready handshakes and a saturating illegal counter.
// Optional macro DECODE_SKID_EN adds a skid entry so in_ready is a register output.
`ifndef ALU_NOP
`define ADD     5'd0
`define SUB     5'd1
`define SLL     5'd2
`define SLT     5'd3
`define SLTU    5'd4
`define XOR     5'd5
`define SRL     5'd6
`define SRA     5'd7
`define OR      5'd8
`define AND     5'd9
`define ALU_NOP 5'd31
`endif

module decode_stage #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [4:0]           alu_control,
  output logic [XLEN-1:0]      imm,
  output logic                 use_imm,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      alu;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  dec_t                 w_dec;
  dec_t                 r_out;
  logic                 r_valid;
  logic [ILL_CNT_W-1:0] r_cnt;
  logic                 w_in_fire;
  logic                 w_out_fire;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [4:0] w_alu;
  logic       w_ok;
  logic       w_is_imm;

  assign w_opcode = instruction_code[6:0];
  assign w_f3     = instruction_code[14:12];
  assign w_f7     = instruction_code[31:25];

  always_comb begin
    w_alu    = `ALU_NOP;
    w_ok     = 1'b0;
    w_is_imm = 1'b0;
    if (w_opcode == 7'b0110011) begin
      w_ok = 1'b1;
      case ({w_f7, w_f3})
        {7'h00, 3'd0}: w_alu = `ADD;
        {7'h20, 3'd0}: w_alu = `SUB;
        {7'h00, 3'd1}: w_alu = `SLL;
        {7'h00, 3'd2}: w_alu = `SLT;
        {7'h00, 3'd3}: w_alu = `SLTU;
        {7'h00, 3'd4}: w_alu = `XOR;
        {7'h00, 3'd5}: w_alu = `SRL;
        {7'h20, 3'd5}: w_alu = `SRA;
        {7'h00, 3'd6}: w_alu = `OR;
        {7'h00, 3'd7}: w_alu = `AND;
        default:       w_ok  = 1'b0;
      endcase
    end else if (w_opcode == 7'b0010011) begin
      w_ok     = 1'b1;
      w_is_imm = 1'b1;
      case (w_f3)
        3'd0: w_alu = `ADD;
        3'd2: w_alu = `SLT;
        3'd3: w_alu = `SLTU;
        3'd4: w_alu = `XOR;
        3'd6: w_alu = `OR;
        3'd7: w_alu = `AND;
        3'd1: if (w_f7 == 7'h00) w_alu = `SLL; else w_ok = 1'b0;
        default: begin
          if (w_f7 == 7'h00)      w_alu = `SRL;
          else if (w_f7 == 7'h20) w_alu = `SRA;
          else                    w_ok  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_dec.rs1       = instruction_code[19:15];
    w_dec.rs2       = instruction_code[24:20];
    w_dec.rd        = instruction_code[11:7];
    w_dec.alu       = `ALU_NOP;
    w_dec.imm       = '0;
    w_dec.use_imm   = 1'b0;
    w_dec.reg_write = 1'b0;
    w_dec.illegal   = !w_ok;
    if (w_ok) begin
      w_dec.alu       = w_alu;
      w_dec.reg_write = (instruction_code[11:7] != 5'd0);
      if (w_is_imm) begin
        w_dec.rs2     = 5'd0;
        w_dec.use_imm = 1'b1;
        // Shift immediates carry only shamt; everything else is a signed 12-bit value.
        if (w_f3 == 3'd1 || w_f3 == 3'd5)
          w_dec.imm = XLEN'(instruction_code[24:20]);
        else
          w_dec.imm = XLEN'(signed'(instruction_code[31:20]));
      end
    end
  end

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_valid && out_ready;

`ifdef DECODE_SKID_EN
  dec_t r_skid;
  logic r_skid_valid;
  logic r_in_ready;

  assign in_ready = r_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_out.alu    <= `ALU_NOP;
      r_valid      <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      if (w_out_fire) begin
        r_out        <= r_skid;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_in_fire) begin
      if (!r_valid || out_ready) begin
        r_out   <= w_dec;
        r_valid <= 1'b1;
      end else begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_out.alu <= `ALU_NOP;
      r_valid   <= 1'b0;
    end else if (w_in_fire) begin
      r_out   <= w_dec;
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_in_fire && w_dec.illegal && (r_cnt != {ILL_CNT_W{1'b1}}))
      r_cnt <= r_cnt + ILL_CNT_W'(1);
  end

  assign out_valid     = r_valid;
  assign rs1           = r_out.rs1;
  assign rs2           = r_out.rs2;
  assign rd            = r_out.rd;
  assign alu_control   = r_out.alu;
  assign imm           = r_out.imm;
  assign use_imm       = r_out.use_imm;
  assign reg_write     = r_out.reg_write;
  assign illegal       = r_out.illegal;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: queue-based reference model plus directed literal checks.
`ifndef ALU_NOP
`define ADD     5'd0
`define SUB     5'd1
`define SLL     5'd2
`define SLT     5'd3
`define SLTU    5'd4
`define XOR     5'd5
`define SRL     5'd6
`define SRA     5'd7
`define OR      5'd8
`define AND     5'd9
`define ALU_NOP 5'd31
`endif

module tb_decode_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [31:0] instruction_code;
  logic        in_ready, out_valid, use_imm, reg_write, illegal;
  logic [4:0]  rs1, rs2, rd, alu_control;
  logic [31:0] imm;
  logic [15:0] illegal_count;

  logic        in_ready2, out_valid2, use_imm2, reg_write2, illegal2;
  logic [4:0]  rs1_2, rs2_2, rd_2, alu2;
  logic [31:0] imm2;
  logic [1:0]  illegal_count2;

  decode_stage #(.XLEN(32), .ILL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_code(instruction_code), .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control), .imm(imm),
    .use_imm(use_imm), .reg_write(reg_write), .illegal(illegal),
    .illegal_count(illegal_count));

  decode_stage #(.XLEN(32), .ILL_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .instruction_code(instruction_code), .out_valid(out_valid2), .out_ready(1'b1),
    .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .alu_control(alu2), .imm(imm2),
    .use_imm(use_imm2), .reg_write(reg_write2), .illegal(illegal2),
    .illegal_count(illegal_count2));

  typedef struct {
    logic [4:0]  rs1, rs2, rd, alu;
    logic [31:0] imm;
    logic        ui, rw, il;
  } ent_t;

`ifdef DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;
  bit   started = 1'b0;
  bit   last_in_fire = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return `ADD;
      3'd1: return `SLL;
      3'd2: return `SLT;
      3'd3: return `SLTU;
      3'd4: return `XOR;
      3'd5: return `SRL;
      3'd6: return `OR;
      default: return `AND;
    endcase
  endfunction

  function automatic ent_t ref_dec(input logic [31:0] w);
    ent_t e;
    int   sel;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    sel = -1;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    e.imm = 32'd0; e.ui = 1'b0;
    if (op == 7'h33) begin
      if (f7 == 7'h00) sel = int'(f3_alu(f3));
      else if (f7 == 7'h20 && f3 == 3'd0) sel = int'(`SUB);
      else if (f7 == 7'h20 && f3 == 3'd5) sel = int'(`SRA);
    end else if (op == 7'h13) begin
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) sel = int'(`SLL);
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00) sel = int'(`SRL);
        else if (f7 == 7'h20) sel = int'(`SRA);
      end else sel = int'(f3_alu(f3));
      if (sel >= 0) begin
        e.ui  = 1'b1;
        e.rs2 = 5'd0;
        if (f3 == 3'd1 || f3 == 3'd5) e.imm = {27'd0, w[24:20]};
        else e.imm = {{20{w[31]}}, w[31:20]};
      end
    end
    e.il  = (sel < 0);
    e.alu = e.il ? `ALU_NOP : 5'(sel);
    e.rw  = !e.il && (e.rd != 5'd0);
    return e;
  endfunction

  // One clock of stimulus; outputs are compared against the model before the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic r);
    bit   exp_rdy, in_fire, out_fire;
    ent_t e;
    @(negedge clk);
    rst = r; in_valid = v; instruction_code = ins; out_ready = ordy;
    #1;
    exp_rdy = (CAP == 1) ? (q.size() == 0 || ordy) : (q.size() < 2);
    if (started) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("illegal_count", 64'(illegal_count), 64'(exp_cnt));
      chk("illegal_count_w2", 64'(illegal_count2), 64'(exp_cnt2));
      chk("in_ready_w2", 64'(in_ready2), 64'd1);
      if (q.size() > 0) begin
        chk("rs1", 64'(rs1), 64'(q[0].rs1));
        chk("rs2", 64'(rs2), 64'(q[0].rs2));
        chk("rd", 64'(rd), 64'(q[0].rd));
        chk("alu_control", 64'(alu_control), 64'(q[0].alu));
        chk("imm", 64'(imm), 64'(q[0].imm));
        chk("use_imm", 64'(use_imm), 64'(q[0].ui));
        chk("reg_write", 64'(reg_write), 64'(q[0].rw));
        chk("illegal", 64'(illegal), 64'(q[0].il));
      end
    end
    e        = ref_dec(ins);
    in_fire  = !r && v && exp_rdy;
    out_fire = !r && (q.size() > 0) && ordy;
    last_in_fire = in_fire;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_cnt  = 0;
      exp_cnt2 = 0;
      started  = 1'b1;
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(e);
      if (in_fire && e.il && exp_cnt < 65535) exp_cnt++;
      if (v && e.il && exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  function automatic logic [6:0] pick7();
    int k;
    k = $urandom_range(0, 3);
    if (k < 2) return 7'h00;
    if (k == 2) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) begin
      w[6:0] = 7'h33; w[31:25] = pick7();
    end else if (k < 8) begin
      w[6:0] = 7'h13;
      if ($urandom_range(0, 1) == 1) w[31:25] = pick7();
    end
    return w;
  endfunction

  logic [31:0] stream [4];
  ent_t        pin;
  int          idx;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instruction_code = 32'd0;
    step(0, 32'd0, 1, 1);
    step(0, 32'd0, 1, 1);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu", 64'(alu_control), 64'(`ALU_NOP));
    chk("rst_fields", 64'({rs1, rs2, rd, imm, use_imm, reg_write, illegal}), 64'd0);
    chk("rst_count", 64'(illegal_count), 64'd0);

    pin = ref_dec(32'h002081B3);
    chk("model_add_alu", 64'(pin.alu), 64'(`ADD));
    pin = ref_dec(32'h40309093);
    chk("model_bad_slli", 64'(pin.il), 64'd1);

    step(1, 32'h002081B3, 1, 0); #1;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_regs", 64'({rs1, rs2, rd}), 64'({5'd1, 5'd2, 5'd3}));
    chk("add_alu", 64'(alu_control), 64'(`ADD));
    chk("add_flags", 64'({use_imm, reg_write, illegal}), 64'b010);

    step(1, 32'hFFF00293, 1, 0); #1;
    chk("addi_alu", 64'(alu_control), 64'(`ADD));
    chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
    chk("addi_use_imm_rd", 64'({use_imm, rd}), 64'({1'b1, 5'd5}));

    step(1, 32'h4030D093, 1, 0); #1;
    chk("srai_alu", 64'(alu_control), 64'(`SRA));
    chk("srai_imm", 64'(imm), 64'd3);

    step(1, 32'h40309093, 1, 0); #1;
    chk("bad_slli_illegal", 64'(illegal), 64'd1);
    chk("bad_slli_alu", 64'(alu_control), 64'(`ALU_NOP));
    chk("bad_slli_rw", 64'(reg_write), 64'd0);
    step(0, 32'd0, 1, 0);

    stream[0] = 32'h002081B3; stream[1] = 32'h40208233;
    stream[2] = 32'h0050C313; stream[3] = 32'h00A3F393;
    idx = 0;
    for (int c = 1; c <= 12; c++) begin
      step(idx < 4, stream[idx % 4], !(c >= 2 && c <= 4), 0);
      if (last_in_fire) idx++;
    end
    chk("stream_all_accepted", 64'(idx), 64'd4);

    step(0, 32'd0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h00000000, 1, 0);
      if (i == 2) begin #1; chk("ill_count_3", 64'(illegal_count), 64'd3); end
    end
    #1;
    chk("ill_count_5", 64'(illegal_count), 64'd5);
    chk("ill_count_sat_w2", 64'(illegal_count2), 64'd3);
    step(0, 32'd0, 1, 1); #1;
    chk("ill_count_after_rst", 64'(illegal_count), 64'd0);
    chk("ill_count_w2_after_rst", 64'(illegal_count2), 64'd0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rnd_ins(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0);
    step(0, 32'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the combinational R-type decoder. It decodes RV32I R-type (OP) and I-type ALU (OP-IMM) instructions into register indices, a 5-bit ALU control code, a sign-extended immediate and write/illegal flags. It sits between instruction fetch and register read, with valid/ready handshakes on both sides and a saturating illegal-instruction counter.

## Interface
Parameters:
- XLEN, 32: immediate output width; minimum 12.
- ILL_CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction_code is valid.
- in_ready  out  1  stage accepts an instruction this cycle.
- instruction_code  in  32  full instruction word.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  downstream accepts the decoded fields.
- rs1, rs2, rd  out  5 each  register indices.
- alu_control  out  5  ALU operation code, using the processor-defines ALU macros.
- imm  out  XLEN  immediate operand.
- use_imm  out  1  ALU operand B is imm, not rs2.
- reg_write  out  1  result is written to rd.
- illegal  out  1  instruction is not a supported OP or OP-IMM encoding.
- illegal_count  out  ILL_CNT_W  number of illegal instructions accepted.

## Operation
- Handshakes: transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
- OP (opcode 7'b0110011): fields are rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - funct3/funct7 map to `ADD, `SUB, `SLL, `SLT, `SLTU, `XOR, `SRL, `SRA, `OR, `AND, as in RV32I.
  - use_imm = 0; imm = 0.
- OP-IMM (opcode 7'b0010011): rs2 = 0; use_imm = 1.
  - funct3 0/2/3/4/6/7 map to `ADD, `SLT, `SLTU, `XOR, `OR, `AND.
  - For these, imm = instruction_code[31:20] sign-extended to XLEN.
  - funct3 1 maps to `SLL only if [31:25] = 7'h00.
  - funct3 5 maps to `SRL if [31:25] = 7'h00 and to `SRA if [31:25] = 7'h20.
  - For shifts, imm = zero-extended [24:20].
- Any other opcode, or an unlisted funct7 or shift encoding:
  - illegal = 1, alu_control = `ALU_NOP, reg_write = 0, use_imm = 0, imm = 0.
  - rs1, rs2 and rd still carry the raw fields.
- reg_write = !illegal && (rd != 0).
- illegal_count increments by 1 on each input transfer whose decode is illegal.
  - It saturates at all-ones and never wraps.

## Timing
- Latency: fields appear on the outputs the cycle after the input transfer.
- Output fields are held stable while out_valid && !out_ready.
- Back-to-back transfers at one instruction per cycle are required when out_ready is held at 1.
- Reset values:
  - out_valid = 0, in_ready = 1.
  - rs1/rs2/rd/imm = 0, alu_control = `ALU_NOP, use_imm/reg_write/illegal = 0.
  - illegal_count = 0.
- While rst is high, handshakes are ignored.
- Reset mid-operation discards all held entries. The counter does not increment in a reset cycle.
- Simultaneous input and output transfer on a full output register: the new entry replaces the old one in the same edge.

## Configuration
- Macro DECODE_SKID_EN.
- Defined: two-entry skid buffer.
  - in_ready is a register output equal to "skid entry empty", so there is no combinational out_ready-to-in_ready path.
  - An input transfer while the output is stalled goes to the skid entry.
  - The skid entry moves to the output on the next output transfer.
  - Full throughput is preserved.
- Undefined: single output register.
  - in_ready = !out_valid || out_ready, combinationally.
- Decode results are identical in both builds.

## Test plan
- Reset, then ADD x3,x1,x2 (32'h002081B3) -> next cycle: out_valid = 1, rs1 = 1, rs2 = 2, rd = 3, alu_control = `ADD, use_imm = 0, reg_write = 1.
- ADDI x5,x0,-1 (32'hFFF00293) -> alu_control = `ADD, imm = 32'hFFFFFFFF, use_imm = 1, rd = 5.
- SRAI x1,x1,3 (32'h4030D093) -> `SRA, imm = 3.
- SLLI with funct7 7'h20 (32'h40309093) -> illegal = 1, `ALU_NOP, reg_write = 0.
- Stream 4 instructions with out_ready low for cycles 2–4 -> no loss, no duplication, order preserved.
  - With DECODE_SKID_EN, in_ready drops only after two entries are held.
- 3 illegal words (32'h00000000) accepted, then rst pulse -> illegal_count reads 3, then 0 after reset.
  - With ILL_CNT_W = 2, 5 illegal words -> illegal_count = 3 (saturated).
